// File: rtl/uart_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_pkg : shared state encodings and frame constants for the UART
// Rev 1.0
// ------------------------------------------------------------------
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int SAMPLE_PT   = 7;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // xr is the XOR of all data bits; even parity sends it as-is
  function automatic logic parity_bit(input logic xr, input int mode);
    return (mode == PARITY_ODD) ? ~xr : xr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_sync_fifo : first-word-fall-through FIFO, AW+1-bit wrap pointers
// Rev 1.0
// ------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_pop,
  output logic [DW-1:0] o_rdata,
  output logic          o_empty,
  output logic          o_full
);

  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [DW-1:0] r_mem [2**AW];
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  // a pop in the same cycle frees the slot, so push is legal even when full
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// uart_fifo_ctrl : single-clock UART, 16x oversampled RX, TX/RX FIFOs
// Rev 1.0
// ------------------------------------------------------------------
module uart_fifo_ctrl #(
  parameter int BAUD_DIV  = 13,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int TX_AW     = 4,
  parameter int RX_AW     = 4
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_wr,
  output logic              tx_full,
  output logic              busy,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_rd,
  input  logic              err_clr,
  output logic              frame_err,
  output logic              parity_err,
  output logic              rx_overrun,
  input  logic              din,
  output logic              dout
);

  import uart_pkg::*;

  localparam int TCW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);

  logic [TCW-1:0] r_tick_cnt;
  logic           w_tick;

  assign w_tick = (r_tick_cnt == TCW'(BAUD_DIV - 1));

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TCW'(1);
  end

  // ---------------- transmitter ----------------
  tx_state_t         r_tx_state, w_tx_next;
  logic [3:0]        r_tx_os;
  logic [BIT_W-1:0]  r_tx_bit;
  logic              r_tx_stop;
  logic [DATA_W-1:0] r_tx_shift;
  logic              r_tx_par;
  logic [DATA_W-1:0] w_tx_head;
  logic              w_tx_empty;
  logic              w_tx_pop;
  logic              w_tx_bit_end;
  logic              w_tx_last_stop;

  uart_sync_fifo #(.DW(DATA_W), .AW(TX_AW)) u_tx_fifo (
    .clk     (sclk),
    .rst_n   (reset),
    .i_push  (tx_wr),
    .i_wdata (tx_data),
    .i_pop   (w_tx_pop),
    .o_rdata (w_tx_head),
    .o_empty (w_tx_empty),
    .o_full  (tx_full)
  );

  assign w_tx_bit_end   = w_tick && (r_tx_os == 4'(OVERSAMPLE - 1));
  assign w_tx_last_stop = (STOP_BITS == 2) ? r_tx_stop : 1'b1;
  assign busy           = ~w_tx_empty | (r_tx_state != TX_IDLE);

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) r_tx_state <= TX_IDLE;
    else        r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    w_tx_pop  = 1'b0;
    case (r_tx_state)
      TX_IDLE: if (w_tick && !w_tx_empty) begin
        w_tx_next = TX_START;
        w_tx_pop  = 1'b1;
      end
      TX_START: if (w_tx_bit_end) w_tx_next = TX_DATA;
      TX_DATA: if (w_tx_bit_end && (r_tx_bit == BIT_W'(DATA_W - 1)))
        w_tx_next = (PARITY != PARITY_NONE) ? TX_PARITY : TX_STOP;
      TX_PARITY: if (w_tx_bit_end) w_tx_next = TX_STOP;
      TX_STOP: if (w_tx_bit_end && w_tx_last_stop) begin
        // next frame follows without an idle bit when data is waiting
        if (!w_tx_empty) begin
          w_tx_next = TX_START;
          w_tx_pop  = 1'b1;
        end else begin
          w_tx_next = TX_IDLE;
        end
      end
      default: w_tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    dout = 1'b1;
    case (r_tx_state)
      TX_START:  dout = 1'b0;
      TX_DATA:   dout = r_tx_shift[0];
      TX_PARITY: dout = r_tx_par;
      default:   dout = 1'b1;
    endcase
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      r_tx_os    <= '0;
      r_tx_bit   <= '0;
      r_tx_stop  <= 1'b0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
    end else if (w_tx_pop) begin
      r_tx_os    <= '0;
      r_tx_bit   <= '0;
      r_tx_stop  <= 1'b0;
      r_tx_shift <= w_tx_head;
      r_tx_par   <= parity_bit(^w_tx_head, PARITY);
    end else if (w_tick) begin
      r_tx_os <= r_tx_os + 4'd1;
      if (w_tx_bit_end && (r_tx_state == TX_DATA)) begin
        r_tx_shift <= {1'b0, r_tx_shift[DATA_W-1:1]};
        r_tx_bit   <= r_tx_bit + BIT_W'(1);
      end
      if (w_tx_bit_end && (r_tx_state == TX_STOP)) r_tx_stop <= ~r_tx_stop;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t         r_rx_state, w_rx_next;
  logic [1:0]        r_sync;
  logic              r_rxd_prev;
  logic              w_rxd;
  logic              w_fall;
  logic [3:0]        r_rx_os;
  logic [BIT_W-1:0]  r_rx_bit;
  logic [DATA_W-1:0] r_rx_shift;
  logic              r_rx_par_bad;
  logic              w_rx_sample;
  logic              w_rx_bit_end;
  logic              w_rx_good;
  logic              w_rx_full;
  logic              w_rx_empty;
  logic              w_rx_pop;
  logic              w_frame_set;
  logic              w_par_set;
  logic              w_ovr_set;

  assign w_rxd        = r_sync[1];
  assign w_fall       = r_rxd_prev & ~w_rxd;
  assign w_rx_sample  = w_tick && (r_rx_os == 4'(SAMPLE_PT));
  assign w_rx_bit_end = w_tick && (r_rx_os == 4'(OVERSAMPLE - 1));
  assign w_rx_pop     = rx_rd & ~w_rx_empty;
  assign rx_valid     = ~w_rx_empty;

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      r_sync     <= 2'b11;
      r_rxd_prev <= 1'b1;
    end else begin
      r_sync     <= {r_sync[0], din};
      r_rxd_prev <= w_rxd;
    end
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) r_rx_state <= RX_IDLE;
    else        r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE:  if (w_fall) w_rx_next = RX_START;
      RX_START: begin
        if (w_rx_sample && w_rxd) w_rx_next = RX_IDLE;
        else if (w_rx_bit_end)    w_rx_next = RX_DATA;
      end
      RX_DATA: if (w_rx_bit_end && (r_rx_bit == BIT_W'(DATA_W - 1)))
        w_rx_next = (PARITY != PARITY_NONE) ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_rx_bit_end) w_rx_next = RX_STOP;
      // leave at mid-stop so the next start edge is never missed
      RX_STOP: if (w_rx_sample) w_rx_next = RX_IDLE;
      default: w_rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    w_rx_good   = (r_rx_state == RX_STOP) && w_rx_sample && w_rxd && !r_rx_par_bad;
    w_frame_set = (r_rx_state == RX_STOP) && w_rx_sample && !w_rxd;
    w_par_set   = (r_rx_state == RX_PARITY) && w_rx_sample &&
                  (w_rxd != parity_bit(^r_rx_shift, PARITY));
    w_ovr_set   = w_rx_good && w_rx_full && !w_rx_pop;
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      r_rx_os      <= '0;
      r_rx_bit     <= '0;
      r_rx_shift   <= '0;
      r_rx_par_bad <= 1'b0;
    end else if ((r_rx_state == RX_IDLE) && w_fall) begin
      r_rx_os      <= '0;
      r_rx_bit     <= '0;
      r_rx_par_bad <= 1'b0;
    end else if (w_tick) begin
      r_rx_os <= r_rx_os + 4'd1;
      if (w_rx_sample && (r_rx_state == RX_DATA))
        r_rx_shift <= {w_rxd, r_rx_shift[DATA_W-1:1]};
      if (w_rx_bit_end && (r_rx_state == RX_DATA)) r_rx_bit <= r_rx_bit + BIT_W'(1);
      if (w_par_set) r_rx_par_bad <= 1'b1;
    end
  end

  uart_sync_fifo #(.DW(DATA_W), .AW(RX_AW)) u_rx_fifo (
    .clk     (sclk),
    .rst_n   (reset),
    .i_push  (w_rx_good),
    .i_wdata (r_rx_shift),
    .i_pop   (w_rx_pop),
    .o_rdata (rx_data),
    .o_empty (w_rx_empty),
    .o_full  (w_rx_full)
  );

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      if (w_frame_set)  frame_err  <= 1'b1;
      else if (err_clr) frame_err  <= 1'b0;
      if (w_par_set)    parity_err <= 1'b1;
      else if (err_clr) parity_err <= 1'b0;
      if (w_ovr_set)    rx_overrun <= 1'b1;
      else if (err_clr) rx_overrun <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_ctrl.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_uart_fifo_ctrl : scoreboard bench for uart_fifo_ctrl (even-parity twin)
// Rev 1.0
// ------------------------------------------------------------------
module tb_uart_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_wr, tx_full, busy, rx_valid, rx_rd, err_clr;
  logic [7:0] rx_data;
  logic       frame_err, parity_err, rx_overrun;
  logic       din, din_drv, loop, dout;

  logic [7:0] p_tx_data, p_rx_data;
  logic       p_tx_wr, p_tx_full, p_busy, p_rx_valid, p_rx_rd, p_err_clr;
  logic       p_frame_err, p_parity_err, p_rx_overrun, p_din, p_dout;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       sel_p;

  always #5 clk = ~clk;
  assign din = loop ? dout : din_drv;

  uart_fifo_ctrl #(.BAUD_DIV(1), .DATA_W(8), .PARITY(0), .STOP_BITS(1), .TX_AW(2), .RX_AW(2)) u_dut (
    .sclk(clk), .reset(rst_n), .tx_data(tx_data), .tx_wr(tx_wr), .tx_full(tx_full),
    .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid), .rx_rd(rx_rd), .err_clr(err_clr),
    .frame_err(frame_err), .parity_err(parity_err), .rx_overrun(rx_overrun),
    .din(din), .dout(dout)
  );

  uart_fifo_ctrl #(.BAUD_DIV(1), .DATA_W(8), .PARITY(2), .STOP_BITS(1), .TX_AW(2), .RX_AW(2)) u_dut_p (
    .sclk(clk), .reset(rst_n), .tx_data(p_tx_data), .tx_wr(p_tx_wr), .tx_full(p_tx_full),
    .busy(p_busy), .rx_data(p_rx_data), .rx_valid(p_rx_valid), .rx_rd(p_rx_rd), .err_clr(p_err_clr),
    .frame_err(p_frame_err), .parity_err(p_parity_err), .rx_overrun(p_rx_overrun),
    .din(p_din), .dout(p_dout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    if (sel_p) p_din = v;
    else       din_drv = v;
    repeat (16) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic use_par, input logic parv,
                            input logic stopv, input logic pop_in_stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (use_par) drive_bit(parv);
    if (pop_in_stop) begin
      din_drv = stopv;
      repeat (3) @(negedge clk);
      if (rx_q.size() == 0) check("pop_head_q", 0, 1);
      else                  check("pop_head", rx_data, rx_q.pop_front());
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
      repeat (12) @(negedge clk);
    end else begin
      drive_bit(stopv);
    end
    if (sel_p) p_din = 1'b1;
    else       din_drv = 1'b1;
  endtask

  task automatic read_rx(input string tag);
    int c = 0;
    while (!rx_valid && c < 400) begin
      @(negedge clk);
      c++;
    end
    if (!rx_valid)             check({tag, "_timeout"}, 0, 1);
    else if (rx_q.size() == 0) check({tag, "_unexpected"}, 0, 1);
    else begin
      check(tag, rx_data, rx_q.pop_front());
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
    end
  endtask

  task automatic tx_write(input logic [7:0] d, input logic accepted);
    tx_data = d;
    tx_wr   = 1'b1;
    if (accepted) tx_q.push_back(d);
    @(negedge clk);
    tx_wr   = 1'b0;
  endtask

  task automatic tx_mon(input int n);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      int c = 0;
      while (dout !== 1'b0 && c < 400) begin
        @(negedge clk);
        c++;
      end
      if (dout !== 1'b0) begin
        check("tx_start_timeout", dout, 0);
        return;
      end
      repeat (8) @(negedge clk);
      check("tx_start", dout, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (16) @(negedge clk);
        b[i] = dout;
      end
      repeat (16) @(negedge clk);
      check("tx_stop", dout, 1);
      if (tx_q.size() == 0) check("tx_unexpected", 0, 1);
      else                  check("tx_byte", b, tx_q.pop_front());
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen_low;
    rst_n = 1'b0; tx_data = '0; tx_wr = 1'b0; rx_rd = 1'b0; err_clr = 1'b0;
    din_drv = 1'b1; loop = 1'b0; sel_p = 1'b0;
    p_tx_data = '0; p_tx_wr = 1'b0; p_rx_rd = 1'b0; p_err_clr = 1'b0; p_din = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_full", tx_full, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_errs", {frame_err, parity_err, rx_overrun}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // single frame
    tx_write(8'hA5, 1'b1);
    tx_mon(1);
    repeat (12) @(negedge clk);
    check("tx_busy_after", busy, 0);

    // fill the TX FIFO behind a running frame; the sixth write must vanish
    fork
      begin
        for (int i = 0; i < 5; i++) tx_write(8'h10 + 8'(i), 1'b1);
        check("tx_full_set", tx_full, 1);
        tx_write(8'hEE, 1'b0);
        check("tx_full_hold", tx_full, 1);
      end
      tx_mon(5);
    join
    repeat (12) @(negedge clk);
    check("tx_busy_after5", busy, 0);
    check("tx_q_drained", tx_q.size(), 0);

    // receive back-to-back bytes
    foreach (rx_q[i]) rx_q.delete(i);
    rx_q.push_back(8'h3C); send_frame(8'h3C, 0, 0, 1, 0);
    rx_q.push_back(8'hFF); send_frame(8'hFF, 0, 0, 1, 0);
    rx_q.push_back(8'h00); send_frame(8'h00, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) read_rx("rx_byte");
    check("rx_no_errs", {frame_err, parity_err, rx_overrun}, 0);

    // loopback dout -> din
    loop = 1'b1;
    rx_q.push_back(8'h5A);
    tx_write(8'h5A, 1'b0);
    read_rx("loop_byte");
    repeat (20) @(negedge clk);
    loop = 1'b0;

    // overrun: fifth byte lost
    for (int i = 0; i < 5; i++) begin
      if (i < 4) rx_q.push_back(8'hC0 + 8'(i));
      send_frame(8'hC0 + 8'(i), 0, 0, 1, 0);
    end
    check("ovr_set", rx_overrun, 1);
    for (int i = 0; i < 4; i++) read_rx("ovr_byte");
    check("ovr_empty", rx_valid, 0);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    check("ovr_clr", rx_overrun, 0);

    // full RX FIFO with a pop during the fifth frame keeps all four slots used
    for (int i = 0; i < 4; i++) begin
      rx_q.push_back(8'h60 + 8'(i));
      send_frame(8'h60 + 8'(i), 0, 0, 1, 0);
    end
    send_frame(8'h77, 0, 0, 1, 1);
    rx_q.push_back(8'h77);
    check("popfull_no_ovr", rx_overrun, 0);
    for (int i = 0; i < 4; i++) read_rx("popfull_byte");
    check("popfull_empty", rx_valid, 0);

    // framing error
    send_frame(8'h55, 0, 0, 0, 0);
    repeat (32) @(negedge clk);
    check("ferr_set", frame_err, 1);
    check("ferr_no_data", rx_valid, 0);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    check("ferr_clr", frame_err, 0);

    // start-bit glitch, then a clean frame to prove resync
    din_drv = 1'b0; repeat (3) @(negedge clk); din_drv = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_data", rx_valid, 0);
    check("glitch_no_ferr", frame_err, 0);
    rx_q.push_back(8'h81); send_frame(8'h81, 0, 0, 1, 0);
    read_rx("glitch_resync");

    // even-parity twin: wrong then right parity for 0x01
    sel_p = 1'b1;
    send_frame(8'h01, 1, 0, 1, 0);
    repeat (8) @(negedge clk);
    check("perr_set", p_parity_err, 1);
    check("perr_no_data", p_rx_valid, 0);
    p_err_clr = 1'b1; @(negedge clk); p_err_clr = 1'b0;
    send_frame(8'h01, 1, 1, 1, 0);
    repeat (8) @(negedge clk);
    check("pgood_valid", p_rx_valid, 1);
    check("pgood_data", p_rx_data, 8'h01);
    check("pgood_no_err", p_parity_err, 0);
    sel_p = 1'b0;

    // reset in the middle of a frame
    tx_write(8'h0F, 1'b0);
    tx_write(8'hF0, 1'b0);
    tx_write(8'h33, 1'b0);
    repeat (40) @(negedge clk);
    check("midtx_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dout", dout, 1);
    check("midrst_busy", busy, 0);
    check("midrst_full", tx_full, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_low = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (dout !== 1'b1) seen_low = 1'b1;
    end
    check("postrst_idle", seen_low, 0);
    check("postrst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
